pwm_cfg_sequencer: RTL and testbench

- Upstream configuration stage for the 16-channel PWM array.
- Accepts host commands through a valid/ready write port and buffers them in a small FIFO.
- Serialises commands onto the PWM array's shared mode/pwm buses, with a one-hot per-channel conf strobe.
- Owns the per-channel ce enable register. Outputs connect bit-for-bit to the PWM instances' conf[i]/ce[i] and to the shared mode/pwm buses.

---
 rtl/pwm_cfg_pkg.sv | 33 +++
 rtl/pwm_cmd_fifo.sv | 54 +++++
 rtl/pwm_cfg_sequencer.sv | 158 +++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared types for the PWM configuration sequencer: command codes, FSM states
// and the layout of a buffered host command.
package pwm_cfg_pkg;

   typedef enum logic [1:0] {
      CMD_CFG   = 2'd0,
      CMD_ENA   = 2'd1,
      CMD_BCAST = 2'd2,
      CMD_RSV   = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

   // wr_data layout: mode in the upper half, duty (or enable mask) in the lower half
   localparam int MODE_MSB = 31;
   localparam int MODE_LSB = 16;
   localparam int DUTY_MSB = 15;
   localparam int DUTY_LSB = 0;

   typedef struct packed {
      cmd_e        cmd;
      logic [3:0]  ch;
      logic [15:0] mode;
      logic [15:0] duty;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/pwm_cmd_fifo.sv
// Registered command FIFO with full/empty flags; DEPTH must be a power of two.
module pwm_cmd_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; flushing the pointers makes old contents unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Buffers host commands and serialises them onto the PWM array's mode/pwm/conf buses.
// Define PWM_CFG_CLAMP_EN to saturate duty at PWM_MAX and flag it with err.
module pwm_cfg_sequencer #(
   parameter int NCH        = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CONF_HOLD  = 2,
   parameter int PWM_MAX    = 256
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [1:0]     wr_cmd,
   input  logic [3:0]     wr_ch,
   input  logic [31:0]    wr_data,
   output logic [15:0]    mode,
   output logic [15:0]    pwm,
   output logic [NCH-1:0] conf,
   output logic [NCH-1:0] ce,
   output logic           busy,
   output logic           done,
   output logic           err
);

   import pwm_cfg_pkg::*;

   localparam int HOLD_W = (CONF_HOLD > 1) ? $clog2(CONF_HOLD) : 1;

`ifdef PWM_CFG_CLAMP_EN
   localparam logic CLAMP_EN = 1'b1;
`else
   localparam logic CLAMP_EN = 1'b0;
`endif

   cmd_t             push_cmd, pop_cmd;
   logic [CMD_W-1:0] pop_raw;
   logic             push, pop, full, empty;

   state_e           state_q, state_d;
   logic [15:0]      mode_q, mode_d, pwm_q, pwm_d;
   logic [NCH-1:0]   conf_q, conf_d, ce_q, ce_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic             clamp_q, clamp_d, done_q, done_d, err_q, err_d;

   logic             over_max;
   logic [15:0]      duty_load;
   logic [NCH-1:0]   ch_onehot;

   assign push_cmd = '{cmd:  cmd_e'(wr_cmd),
                       ch:   wr_ch,
                       mode: wr_data[MODE_MSB:MODE_LSB],
                       duty: wr_data[DUTY_MSB:DUTY_LSB]};
   assign wr_ready = !full;
   assign push     = wr_valid && !full;

   pwm_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_cmd),
      .full  (full),
      .pop   (pop),
      .dout  (pop_raw),
      .empty (empty)
   );

   assign pop_cmd   = cmd_t'(pop_raw);
   assign over_max  = pop_cmd.duty > 16'(PWM_MAX);
   assign duty_load = (CLAMP_EN && over_max) ? 16'(PWM_MAX) : pop_cmd.duty;
   assign ch_onehot = NCH'(1) << pop_cmd.ch;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pwm_d   = pwm_q;
      conf_d  = conf_q;
      ce_d    = ce_q;
      hold_d  = hold_q;
      clamp_d = clamp_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               unique case (pop_cmd.cmd)
                  CMD_CFG, CMD_BCAST: begin
                     mode_d  = pop_cmd.mode;
                     pwm_d   = duty_load;
                     clamp_d = CLAMP_EN && over_max;
                     // Broadcast targets whichever channels are enabled right now.
                     conf_d  = (pop_cmd.cmd == CMD_CFG) ? ch_onehot : ce_q;
                     hold_d  = HOLD_W'(CONF_HOLD - 1);
                     state_d = ST_LOAD;
                  end
                  CMD_ENA: begin
                     ce_d   = pop_cmd.duty[NCH-1:0];
                     done_d = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_LOAD: begin
            if (hold_q == '0) begin
               conf_d  = '0;
               state_d = ST_SETTLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_SETTLE: begin
            done_d  = 1'b1;
            err_d   = clamp_q;
            clamp_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= '0;
         pwm_q   <= '0;
         conf_q  <= '0;
         ce_q    <= '0;
         hold_q  <= '0;
         clamp_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pwm_q   <= pwm_d;
         conf_q  <= conf_d;
         ce_q    <= ce_d;
         hold_q  <= hold_d;
         clamp_q <= clamp_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mode = mode_q;
   assign pwm  = pwm_q;
   assign conf = conf_q;
   assign ce   = ce_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer with hand-computed expectations.
module tb_pwm_cfg_sequencer;

   logic        clk, reset, wr_valid, wr_ready;
   logic [1:0]  wr_cmd;
   logic [3:0]  wr_ch;
   logic [31:0] wr_data;
   logic [15:0] mode, pwm, conf, ce;
   logic        busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef PWM_CFG_CLAMP_EN
   localparam logic [15:0] PWM_OVER_EXP = 16'd256;
   localparam logic        ERR_OVER_EXP = 1'b1;
`else
   localparam logic [15:0] PWM_OVER_EXP = 16'd300;
   localparam logic        ERR_OVER_EXP = 1'b0;
`endif

   pwm_cfg_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_cmd   (wr_cmd),
      .wr_ch    (wr_ch),
      .wr_data  (wr_data),
      .mode     (mode),
      .pwm      (pwm),
      .conf     (conf),
      .ce       (ce),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the command until accepted; returns 1 ns after the accepting edge.
   task automatic push(input logic [1:0] c, input logic [3:0] ch, input logic [31:0] d);
      logic acc;
      acc      = 1'b0;
      wr_valid = 1'b1;
      wr_cmd   = c;
      wr_ch    = ch;
      wr_data  = d;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = wr_ready;
         tick();
      end
      wr_valid = 1'b0;
      check("push_accept", acc, 1);
   endtask

   initial begin
      int dcnt;
      int ecnt;

      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_cmd   = '0;
      wr_ch    = '0;
      wr_data  = '0;
      #1;
      check("rst_mode", mode, 0);
      check("rst_pwm", pwm, 0);
      check("rst_conf", conf, 0);
      check("rst_ce", ce, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", wr_ready, 1);
      tick();
      tick();
      reset = 1'b0;

      // CFG ch0, duty exactly PWM_MAX
      push(2'd0, 4'd0, 32'h0000_0100);
      check("t1_busy", busy, 1);
      check("t1_conf_pre", conf, 0);
      tick();
      check("t1_conf_a", conf, 16'h0001);
      check("t1_pwm", pwm, 16'h0100);
      check("t1_mode", mode, 0);
      tick();
      check("t1_conf_b", conf, 16'h0001);
      check("t1_done_early", done, 0);
      tick();
      check("t1_conf_settle", conf, 0);
      check("t1_pwm_settle", pwm, 16'h0100);
      check("t1_done_settle", done, 0);
      tick();
      check("t1_done", done, 1);
      check("t1_err", err, 0);
      check("t1_busy_idle", busy, 0);
      tick();
      check("t1_done_clr", done, 0);

      // ENA then BCAST
      push(2'd1, 4'd0, 32'h0000_0005);
      check("t2_ce_pre", ce, 0);
      tick();
      check("t2_ce", ce, 16'h0005);
      check("t2_ena_done", done, 1);
      check("t2_ena_conf", conf, 0);
      push(2'd2, 4'd0, 32'h0000_0040);
      check("t2_done_clr", done, 0);
      tick();
      check("t2_conf_a", conf, 16'h0005);
      check("t2_pwm", pwm, 16'h0040);
      tick();
      check("t2_conf_b", conf, 16'h0005);
      tick();
      check("t2_conf_off", conf, 0);
      tick();
      check("t2_done", done, 1);
      check("t2_ce_kept", ce, 16'h0005);

      // Five CFGs back-to-back; first is popped while the second is accepted
      for (int k = 0; k < 5; k++) begin
         wr_valid = 1'b1;
         wr_cmd   = 2'd0;
         wr_ch    = 4'(k);
         wr_data  = {16'hA000 | 16'(k), 16'h0010 + 16'(k)};
         check("t3_ready", wr_ready, 1);
         tick();
         if (k == 1) begin
            check("t3_c0_conf", conf, 16'h0001);
            check("t3_c0_mode", mode, 16'hA000);
            check("t3_c0_pwm", pwm, 16'h0010);
         end
      end
      wr_valid = 1'b0;
      check("t3_full_ready", wr_ready, 0);
      check("t3_c0_done", done, 1);
      for (int j = 1; j < 5; j++) begin
         dcnt = 0;
         tick();
         check("t3_conf", conf, 16'h0001 << j);
         check("t3_mode", mode, 16'hA000 | 16'(j));
         check("t3_pwm", pwm, 16'h0010 + 16'(j));
         if (j == 1) check("t3_ready_back", wr_ready, 1);
         dcnt += int'(done);
         tick();
         dcnt += int'(done);
         tick();
         dcnt += int'(done);
         tick();
         dcnt += int'(done);
         check("t3_done", done, 1);
         check("t3_done_cnt", dcnt, 1);
      end
      tick();
      check("t3_idle", busy, 0);

      // Reserved command sandwiched between two CFGs
      push(2'd0, 4'd2, {16'h1234, 16'h0055});
      push(2'd3, 4'd15, 32'hFFFF_FFFF);
      push(2'd0, 4'd3, {16'h4321, 16'h0066});
      ecnt = 0;
      dcnt = 0;
      for (int i = 3; i <= 10; i++) begin
         tick();
         ecnt += int'(err);
         dcnt += int'(done);
         if (i == 5) begin
            check("t4_err", err, 1);
            check("t4_err_done", done, 0);
            check("t4_mode_kept", mode, 16'h1234);
            check("t4_pwm_kept", pwm, 16'h0055);
            check("t4_conf_kept", conf, 0);
            check("t4_ce_kept", ce, 16'h0005);
         end
         if (i == 6) begin
            check("t4_conf_b", conf, 16'h0008);
            check("t4_mode_b", mode, 16'h4321);
            check("t4_pwm_b", pwm, 16'h0066);
         end
         if (i == 9) check("t4_done_b", done, 1);
      end
      check("t4_err_cnt", ecnt, 1);
      check("t4_done_cnt", dcnt, 2);

      // Reset during LOAD with a second entry still queued
      push(2'd0, 4'd1, {16'h0007, 16'h0020});
      push(2'd0, 4'd5, {16'h0008, 16'h0030});
      check("t5_conf_load", conf, 16'h0002);
      #2;
      reset = 1'b1;
      #1;
      check("t5_conf", conf, 0);
      check("t5_mode", mode, 0);
      check("t5_pwm", pwm, 0);
      check("t5_ce", ce, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_err", err, 0);
      check("t5_ready", wr_ready, 1);
      tick();
      reset = 1'b0;
      dcnt = 0;
      ecnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         dcnt += int'(done);
         ecnt += int'(conf != 0);
      end
      check("t5_no_done", dcnt, 0);
      check("t5_no_conf", ecnt, 0);
      check("t5_busy_after", busy, 0);

      // BCAST with no channels enabled: no strobe, same timing
      push(2'd2, 4'd0, {16'h0003, 16'h0010});
      tick();
      check("t6_conf", conf, 0);
      check("t6_pwm", pwm, 16'h0010);
      check("t6_mode", mode, 16'h0003);
      check("t6_busy", busy, 1);
      tick();
      tick();
      check("t6_done_early", done, 0);
      tick();
      check("t6_done", done, 1);

      // Duty above PWM_MAX
      push(2'd0, 4'd4, {16'h0009, 16'd300});
      tick();
      check("t7_conf", conf, 16'h0010);
      check("t7_pwm", pwm, PWM_OVER_EXP);
      tick();
      tick();
      check("t7_err_settle", err, 0);
      tick();
      check("t7_done", done, 1);
      check("t7_err", err, ERR_OVER_EXP);
      tick();
      check("t7_done_clr", done, 0);
      check("t7_err_clr", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
